// File: rtl/lau_pkg.sv
// rtl/lau_pkg.sv - shared types and constants for the add/sub unit and its arbiter
// Contents:
//   speed_e      datapath implementation selector (SLOW ripple, FAST operator adder)
//   arb_state_e  result register occupancy (EMPTY, FULL)
//   PerfCntWidth width of each per-requester grant counter
//   idx_width()  requester index width, never below 1 bit
package lau_pkg;

  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  localparam int PerfCntWidth = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/AddSubV.sv
// rtl/AddSubV.sv - combinational add/subtract with 2's-complement overflow flag
// Parameters: width (word width), speed (FAST operator adder / SLOW ripple chain)
// Ports:
//   A, B  in  width  operands
//   CI    in  1      carry-in (borrow-in when subtracting)
//   SUB   in  1      1: S = A - B - CI, 0: S = A + B + CI
//   S     out width  sum / difference
//   V     out 1      signed overflow
module AddSubV
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic [width-1:0] S,
  output logic             V
);

  // A - B - CI == A + ~B + ~CI in width-bit 2's complement
  logic [width-1:0] b_eff;
  logic             c_eff;

  assign b_eff = SUB ? ~B : B;
  assign c_eff = SUB ? ~CI : CI;

  generate
    if (speed == FAST) begin : g_fast
      assign S = A + b_eff + width'(c_eff);
    end else begin : g_ripple
      logic carry;
      always_comb begin
        carry = c_eff;
        S     = '0;
        for (int i = 0; i < width; i++) begin
          S[i]  = A[i] ^ b_eff[i] ^ carry;
          carry = (A[i] & b_eff[i]) | (carry & (A[i] ^ b_eff[i]));
        end
      end
    end
  endgenerate

  // Overflow: both effective addends share a sign that the result does not
  assign V = (A[width-1] == b_eff[width-1]) && (S[width-1] != A[width-1]);

endmodule

// File: rtl/addsub_rr_pick.sv
// rtl/addsub_rr_pick.sv - round-robin pick of the first valid requester at or after ptr
// Parameters: NumReq (requesters), IdxW (index width)
// Ports:
//   valid  in  NumReq  request vector
//   ptr    in  IdxW    highest-priority index for this cycle
//   grant  out NumReq  one-hot pick, zero when nothing is valid
//   idx    out IdxW    binary index of the pick
//   any    out 1       some requester is valid
module addsub_rr_pick
  import lau_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   idx,
  output logic              any
);

  localparam logic [IdxW:0] NumReqW = (IdxW + 1)'(NumReq);

  // Scan ptr, ptr+1, ... wrapping at NumReq; the first valid hit wins
  always_comb begin
    logic [IdxW:0]   sum;
    logic [IdxW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < NumReq; k++) begin
      sum = {1'b0, ptr} + (IdxW + 1)'(k);
      if (sum >= NumReqW) sum = sum - NumReqW;
      j = sum[IdxW-1:0];
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// rtl/addsub_rr_arbiter.sv - round-robin arbiter sharing one AddSubV over NumReq requesters
// Parameters: width, speed (passed to AddSubV), NumReq (1..16)
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   per-requester handshake, ready is one-hot or zero
//   req_a_i, req_b_i          per-requester operands
//   req_ci_i, req_sub_i       per-requester carry-in and subtract enable
//   rsp_valid_o/rsp_ready_i   result handshake
//   rsp_s_o, rsp_v_o          registered result and overflow
//   rsp_id_o                  index of the requester that produced the result
//   perf_grant_cnt_o          saturating grant counters, only with ADDSUB_ARB_PERF_EN
module addsub_rr_arbiter
  import lau_pkg::*;
#(
  parameter int     width  = 8,
  parameter speed_e speed  = FAST,
  parameter int     NumReq = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][width-1:0]        req_a_i,
  input  logic [NumReq-1:0][width-1:0]        req_b_i,
  input  logic [NumReq-1:0]                   req_ci_i,
  input  logic [NumReq-1:0]                   req_sub_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [width-1:0]                    rsp_s_o,
  output logic                                rsp_v_o,
  output logic [idx_width(NumReq)-1:0]        rsp_id_o
`ifdef ADDSUB_ARB_PERF_EN
  ,
  output logic [NumReq-1:0][PerfCntWidth-1:0] perf_grant_cnt_o
`endif
);

  localparam int            IdxW    = idx_width(NumReq);
  localparam logic [IdxW:0] NumReqW = (IdxW + 1)'(NumReq);

  arb_state_e        state;
  logic [IdxW-1:0]   ptr;
  logic [IdxW-1:0]   ptr_next;
  logic [IdxW:0]     idx_inc;
  logic [NumReq-1:0] grant;
  logic [IdxW-1:0]   idx;
  logic              any;
  logic              can_accept;
  logic              fire;
  logic [width-1:0]  a_sel;
  logic [width-1:0]  b_sel;
  logic              ci_sel;
  logic              sub_sel;
  logic [width-1:0]  sum;
  logic              ovf;

  addsub_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  // A full register can take a new result in the same cycle it is drained
  assign can_accept  = (state == EMPTY) || rsp_ready_i;
  assign fire        = can_accept && any;
  // Gated by reset so nothing is accepted while the result register is held clear
  assign req_ready_o = (fire && rst_ni) ? grant : '0;
  assign rsp_valid_o = (state == FULL);

  // One-hot AND-OR operand mux
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    ci_sel  = 1'b0;
    sub_sel = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant[i]) begin
        a_sel   = a_sel | req_a_i[i];
        b_sel   = b_sel | req_b_i[i];
        ci_sel  = ci_sel | req_ci_i[i];
        sub_sel = sub_sel | req_sub_i[i];
      end
    end
  end

  AddSubV #(
    .width (width),
    .speed (speed)
  ) u_addsub (
    .A   (a_sel),
    .B   (b_sel),
    .CI  (ci_sel),
    .SUB (sub_sel),
    .S   (sum),
    .V   (ovf)
  );

  assign idx_inc  = {1'b0, idx} + (IdxW + 1)'(1);
  assign ptr_next = (idx_inc >= NumReqW) ? '0 : idx_inc[IdxW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= EMPTY;
      ptr      <= '0;
      rsp_s_o  <= '0;
      rsp_v_o  <= 1'b0;
      rsp_id_o <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (fire) begin
            state    <= FULL;
            ptr      <= ptr_next;
            rsp_s_o  <= sum;
            rsp_v_o  <= ovf;
            rsp_id_o <= idx;
          end
        end
        FULL: begin
          if (fire) begin
            ptr      <= ptr_next;
            rsp_s_o  <= sum;
            rsp_v_o  <= ovf;
            rsp_id_o <= idx;
          end else if (rsp_ready_i) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef ADDSUB_ARB_PERF_EN
  for (genvar g = 0; g < NumReq; g++) begin : g_perf
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        perf_grant_cnt_o[g] <= '0;
      end else if (fire && grant[g] && (perf_grant_cnt_o[g] != '1)) begin
        perf_grant_cnt_o[g] <= perf_grant_cnt_o[g] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb/tb_addsub_rr_arbiter.sv - self-checking bench for addsub_rr_arbiter (width=8, NumReq=3)
module tb_addsub_rr_arbiter;

  logic            clk;
  logic            rst_n;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [2:0][7:0] req_a;
  logic [2:0][7:0] req_b;
  logic [2:0]      req_ci;
  logic [2:0]      req_sub;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_s;
  logic            rsp_v;
  logic [1:0]      rsp_id;
`ifdef ADDSUB_ARB_PERF_EN
  logic [2:0][15:0] perf_cnt;
`endif

  addsub_rr_arbiter #(
    .width  (8),
    .NumReq (3)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ci_i    (req_ci),
    .req_sub_i   (req_sub),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_s_o     (rsp_s),
    .rsp_v_o     (rsp_v),
    .rsp_id_o    (rsp_id)
`ifdef ADDSUB_ARB_PERF_EN
    ,
    .perf_grant_cnt_o (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester side: each holds its operation until accepted
  bit        pend [3];
  bit  [7:0] pa   [3];
  bit  [7:0] pb   [3];
  bit        pci  [3];
  bit        psub [3];
  bit        rdy;
  bit        refill;

  // Reference model state
  bit        m_full;
  int        m_ptr;
  bit  [7:0] m_s;
  bit        m_v;
  int        m_id;
  int        obs_grant;
  int        seq [5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Signed arithmetic on the operands' integer values; overflow is leaving [-128,127]
  task automatic calc(input bit [7:0] a, input bit [7:0] b, input bit ci, input bit sub,
                      output bit [7:0] s, output bit v);
    int sa, sb, r;
    sa = (a >= 128) ? int'(a) - 256 : int'(a);
    sb = (b >= 128) ? int'(b) - 256 : int'(b);
    r  = sub ? (sa - sb - int'(ci)) : (sa + sb + int'(ci));
    v  = (r > 127) || (r < -128);
    s  = 8'(r);
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    pa[i]   = 8'($urandom);
    pb[i]   = 8'($urandom);
    pci[i]  = 1'($urandom);
    psub[i] = 1'($urandom);
  endtask

  task automatic set_req(input int i, input bit [7:0] a, input bit [7:0] b, input bit ci, input bit sub);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    pci[i]  = ci;
    psub[i] = sub;
  endtask

  // One clock: drive, check at negedge against the model, advance the model, land at posedge+1
  task automatic step();
    int        g;
    logic [2:0] exp_ready;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = pend[i];
      req_a[i]     = pa[i];
      req_b[i]     = pb[i];
      req_ci[i]    = pci[i];
      req_sub[i]   = psub[i];
    end
    rsp_ready = rdy;
    @(negedge clk);
    g = -1;
    if (!m_full || rdy) begin
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && pend[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      end
    end
    exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    if (m_full) begin
      chk("rsp_s", 32'(rsp_s), 32'(m_s));
      chk("rsp_v", 32'(rsp_v), 32'(m_v));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
    end
    obs_grant = -1;
    for (int i = 0; i < 3; i++) if (req_ready[i]) obs_grant = i;
    if (g >= 0) begin
      calc(pa[g], pb[g], pci[g], psub[g], m_s, m_v);
      m_id    = g;
      m_full  = 1'b1;
      m_ptr   = (g + 1) % 3;
      pend[g] = 1'b0;
      if (refill) new_req(g);
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_full = 1'b0;
    m_ptr  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pci[i] = 1'b0; psub[i] = 1'b0;
    end
    rdy = 1'b1; refill = 1'b0; m_full = 1'b0; m_ptr = 0; m_s = '0; m_v = 1'b0; m_id = 0;
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_a     = '0;
    req_b     = '0;
    req_ci    = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests present
    #3;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_s", 32'(rsp_s), 32'd0);
    chk("rst_v", 32'(rsp_v), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed arithmetic cases
    set_req(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    step();
    chk("add_ovf_valid", 32'(rsp_valid), 32'd1);
    chk("add_ovf_s", 32'(rsp_s), 32'h80);
    chk("add_ovf_v", 32'(rsp_v), 32'd1);
    chk("add_ovf_id", 32'(rsp_id), 32'd0);
    set_req(1, 8'h80, 8'h01, 1'b0, 1'b1);
    step();
    chk("sub_ovf_s", 32'(rsp_s), 32'h7F);
    chk("sub_ovf_v", 32'(rsp_v), 32'd1);
    chk("sub_ovf_id", 32'(rsp_id), 32'd1);
    set_req(2, 8'h05, 8'h02, 1'b1, 1'b1);
    step();
    chk("sub_ci_s", 32'(rsp_s), 32'h02);
    chk("sub_ci_v", 32'(rsp_v), 32'd0);
    chk("sub_ci_id", 32'(rsp_id), 32'd2);

    // All requesters busy, consumer always ready: strict rotation
    refill = 1'b1;
    for (int i = 0; i < 3; i++) new_req(i);
    seq = '{0, 1, 2, 0, 1};
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("rr_grant%0d", n), 32'(obs_grant), 32'(seq[n]));
    end

    // Back-pressure for 5 cycles, then drain with same-cycle regrant
    rdy = 1'b0;
    for (int n = 0; n < 5; n++) step();
    rdy = 1'b1;
    step();
    chk("regrant_idx", 32'(obs_grant), 32'd2);
    chk("regrant_full", 32'(rsp_valid), 32'd1);
    step();

    // Reset while FULL: cleared at once, pointer back to 0
    rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    m_full = 1'b0;
    m_ptr  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy = 1'b1;
    step();
    chk("post_rst_grant", 32'(obs_grant), 32'd0);

    // Randomised traffic with random back-pressure
    refill = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 3; i++) if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end

`ifdef ADDSUB_ARB_PERF_EN
    pend[1] = 1'b0;
    pend[2] = 1'b0;
    rdy     = 1'b1;
    do_reset();
    new_req(0);
    refill = 1'b1;
    for (int n = 0; n < 70000; n++) begin
      step();
      pend[1] = 1'b0;
      pend[2] = 1'b0;
    end
    chk("perf0", 32'(perf_cnt[0]), 32'hFFFF);
    chk("perf1", 32'(perf_cnt[1]), 32'd0);
    chk("perf2", 32'(perf_cnt[2]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
